// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC arctangent sequencer: default widths,
// the Q16 arctangent table and the sequencer state encoding.
package cordic_pkg;

    localparam int ANGLE_W_DEF   = 32;
    localparam int FRAC_BITS_DEF = 16;
    localparam int MAX_ITERS_DEF = 17;
    localparam int IDX_W_DEF     = 5;

    // floor(atan(2^-i) * 2^16). Every entry past the last one is 0 at this
    // precision, so the table covers any depth for FRAC_BITS <= 16.
    localparam int          ATAN_DEPTH = 17;
    localparam int          ATAN_FRAC  = 16;
    localparam logic [31:0] ATAN_Q16 [ATAN_DEPTH] = '{
        32'd51471, 32'd30385, 32'd16054, 32'd8149, 32'd4090, 32'd2047,
        32'd1023,  32'd511,   32'd255,   32'd127,  32'd63,   32'd31,
        32'd15,    32'd7,     32'd3,     32'd1,    32'd0
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [31:0] atan_q16(input int i);
        logic [31:0] val;
        val = '0;
        if (i >= 0 && i < ATAN_DEPTH) begin
            val = ATAN_Q16[i];
        end
        return val;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index in, angle word out.
// Indices at or beyond MAX_ITERS read as zero.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int ANGLE_W   = ANGLE_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int MAX_ITERS = MAX_ITERS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic [IDX_W-1:0]   idx_i,
    output logic [ANGLE_W-1:0] angle_o
);

    // Right-shifting a floored Q16 value keeps the result floored, so
    // narrower fractions stay exact.
    localparam int SHIFT = ATAN_FRAC - FRAC_BITS;

    logic [31:0] q16_val;

    always_comb begin
        q16_val = '0;
        angle_o = '0;
        if (int'(idx_i) < MAX_ITERS) begin
            q16_val = atan_q16(int'(idx_i));
            angle_o = ANGLE_W'(q16_val >> SHIFT);
        end
    end

endmodule

// File: rtl/cordic_atan_sequencer.sv
// Streams one arctangent beat per accepted handshake for a requested number
// of CORDIC iterations, between the control FSM and the iteration datapath.
module cordic_atan_sequencer
    import cordic_pkg::*;
#(
    parameter int ANGLE_W   = ANGLE_W_DEF,
    parameter int FRAC_BITS = FRAC_BITS_DEF,
    parameter int MAX_ITERS = MAX_ITERS_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IDX_W-1:0]   iters,
    input  logic               abort,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_idx,
    output logic [IDX_W-1:0]   out_shift,
    output logic [ANGLE_W-1:0] out_angle,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    // Handshake: a beat transfers on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready is low
    // the payload holds, and out_valid never drops without a transfer unless
    // abort or reset intervenes.

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     n_q, n_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ANGLE_W-1:0]   angle_q, angle_d;
    logic                 last_q, last_d;

    logic [IDX_W-1:0]     n_sat;
    logic [IDX_W-1:0]     rom_idx;
    logic [ANGLE_W-1:0]   rom_angle;
    logic                 accept_start;
    logic                 fire;

    cordic_atan_rom #(
        .ANGLE_W   (ANGLE_W),
        .FRAC_BITS (FRAC_BITS),
        .MAX_ITERS (MAX_ITERS),
        .IDX_W     (IDX_W)
    ) u_rom (
        .idx_i   (rom_idx),
        .angle_o (rom_angle)
    );

    // Zero and oversized requests both mean a full-depth sequence.
    always_comb begin
        if (iters == '0 || int'(iters) > MAX_ITERS) begin
            n_sat = IDX_W'(MAX_ITERS);
        end else begin
            n_sat = iters;
        end
    end

    assign accept_start = (state_q == ST_IDLE) && start && !abort;
    assign fire         = (state_q == ST_RUN) && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort || (fire && last_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = (state_q == ST_RUN);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DRAIN);
        out_idx   = idx_q;
        out_shift = idx_q;
        out_angle = angle_q;
        out_last  = last_q;
    end

    // Beat loading: beat 0 on start, idx+1 in the same edge a non-last beat
    // transfers, so an always-ready consumer sees one beat per clock.
    always_comb begin
        n_d     = n_q;
        idx_d   = idx_q;
        angle_d = angle_q;
        last_d  = last_q;
        rom_idx = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept_start) begin
                    n_d     = n_sat;
                    idx_d   = '0;
                    angle_d = rom_angle;
                    last_d  = (n_sat == IDX_W'(1));
                end
            end
            ST_RUN: begin
                rom_idx = idx_q + IDX_W'(1);
                if (fire && !last_q && !abort) begin
                    idx_d   = idx_q + IDX_W'(1);
                    angle_d = rom_angle;
                    last_d  = ((idx_q + IDX_W'(2)) == n_q);
                end
            end
            default: begin
                rom_idx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= '0;
            idx_q   <= '0;
            angle_q <= '0;
            last_q  <= 1'b0;
        end else begin
            n_q     <= n_d;
            idx_q   <= idx_d;
            angle_q <= angle_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: doc/cordic_atan_sequencer.md
Name: cordic_atan_sequencer

Overview:
Parametrised successor of the fixed 17-entry arctan table. It holds a table of atan(2^-i) values and, on a start request, streams one entry per accepted beat for a programmable number of CORDIC iterations. Each beat carries the iteration index, the shift amount, the angle and a last flag, with valid/ready flow control. It sits between the CORDIC control FSM and the iteration datapath and replaces the combinational index lookup.

Parameters:
ANGLE_W, 32, angle word width, signed two's complement.
FRAC_BITS, 16, fractional bits of angle; 1.0 rad = 2^FRAC_BITS.
MAX_ITERS, 17, table depth; indices 0..MAX_ITERS-1.
IDX_W, 5, width of index/count fields; must satisfy 2^IDX_W >= MAX_ITERS+1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sequence; sampled only in IDLE
iters  in  IDX_W  iterations requested; sampled with start
abort  in  1  terminate sequence; highest priority after reset
out_ready  in  1  consumer accepts current beat
out_valid  out  1  beat valid
out_idx  out  IDX_W  iteration index i
out_shift  out  IDX_W  shift amount for x/y, equal to i
out_angle  out  ANGLE_W  floor(atan(2^-i)*2^FRAC_BITS)
out_last  out  1  final beat of the sequence
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse after the last beat is accepted or after abort

Behaviour:
- Reset (async assert, sync release): state=IDLE, all outputs 0, internal count=0.
- Table: entry i = floor(atan(2^-i)*2^FRAC_BITS), sign-extended to ANGLE_W. Defaults for i=0..16: 51471, 30385, 16054, 8149, 4090, 2047, 1023, 511, 255, 127, 63, 31, 15, 7, 3, 1, 0.
- Iteration count N is latched at start:
  - iters=0 gives N=MAX_ITERS.
  - iters>MAX_ITERS saturates to MAX_ITERS.
  - Otherwise N=iters.
- States:
  - IDLE: start=1 latches N, loads beat 0 into the output register and goes to RUN. out_valid rises the cycle after start (latency 1).
  - RUN: a beat transfers when out_valid&out_ready. On transfer of a non-last beat, the next beat (idx+1) loads in the same edge, so back-to-back throughput is 1 beat/clk. On transfer of the last beat, go to DRAIN.
  - DRAIN: out_valid=0, done=1 for exactly one cycle, then IDLE.
- Stall: while out_valid=1 and out_ready=0, out_idx, out_shift, out_angle and out_last hold stable.
- out_last=1 exactly when out_idx=N-1. For N=1 the first beat is also the last.
- start outside IDLE is ignored; the in-flight sequence is unaffected.
- start in the DRAIN cycle is ignored. start in the following IDLE cycle is accepted.
- abort in RUN:
  - Next edge: out_valid=0 and state goes to DRAIN, so done pulses.
  - A beat handshaking in the same cycle as abort is counted as transferred, but no further beat follows.
- abort in IDLE or DRAIN: no effect.
- abort and start together in IDLE: abort wins and the sequence does not begin.
- busy=1 in RUN and DRAIN, 0 in IDLE.
- Index arithmetic is unsigned IDX_W bits. The index never exceeds MAX_ITERS-1, so it never wraps.
- Reset asserted mid-sequence: outputs clear immediately, with no done pulse.

Decomposition:
- Package cordic_pkg:
  - ANGLE_W/FRAC_BITS/MAX_ITERS defaults.
  - The atan constant array, plus a constant function returning entry i.
  - State enum {IDLE, RUN, DRAIN}.
- Sub-module cordic_atan_rom: combinational, parametrised, index to angle, reading the package array. Out-of-range index returns 0.
- The sequencer contains the FSM, the counter and the output register.

Test Plan:
- Reset, then start with iters=0 and out_ready held 1 -> 17 consecutive beats, idx 0..16, angles 51471..0 as tabled, out_last only on idx 16, done pulse on the cycle after, busy low 2 cycles after the last beat.
- start with iters=3 and out_ready toggling 1,0,0,1,1 -> beats idx 0,1,2 with angles 51471, 30385, 16054; payload stable while stalled; out_last on idx 2.
- iters=20 -> saturates to 17 beats. iters=1 -> a single beat, angle 51471, out_last=1.
- abort asserted while idx=5 is pending with out_ready=0 -> out_valid drops next cycle, done pulses, and a later start restarts at idx 0.
- start pulsed during RUN and during DRAIN -> ignored. start on the first IDLE cycle after done -> a new sequence with latency 1.
- rst_n asserted mid-sequence, asynchronously between clock edges -> all outputs 0 immediately. After release, start with iters=2 gives idx 0,1.
